// File: rtl/tile_pkg.sv
// Shared constants and types for the tile blitter and its neighbours.
package tile_pkg;

  localparam logic MODE_ERASE = 1'b0;
  localparam logic MODE_DRAW  = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain
  } tile_state_e;

  // Default geometry, shared with the game FSM and the VGA top.
  localparam int unsigned DEF_TILE_W   = 20;
  localparam int unsigned DEF_TILE_H   = 20;
  localparam int unsigned DEF_SCREEN_W = 160;
  localparam int unsigned DEF_SCREEN_H = 120;

  // clog2 that never returns zero, so single-entry ranges still get a 1-bit field.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/tile_scan_counter.sv
// Raster counter over a TILE_W x TILE_H area with clear, enable and last-pixel flag.
module tile_scan_counter
  import tile_pkg::*;
#(
  parameter int unsigned TILE_W = DEF_TILE_W,
  parameter int unsigned TILE_H = DEF_TILE_H,
  parameter int unsigned CX_W   = clog2_min1(TILE_W),
  parameter int unsigned CY_W   = clog2_min1(TILE_H)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [CX_W-1:0] cx_o,
  output logic [CY_W-1:0] cy_o,
  output logic            last_o
);

  logic [CX_W-1:0] cx_q, cx_d;
  logic [CY_W-1:0] cy_q, cy_d;
  logic            x_end, y_end;

  // Next-state: clear wins, otherwise step in raster order and wrap after the last pixel.
  always_comb begin
    cx_d  = cx_q;
    cy_d  = cy_q;
    x_end = (cx_q == CX_W'(TILE_W - 1));
    y_end = (cy_q == CY_W'(TILE_H - 1));
    if (clr_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (en_i) begin
      if (x_end) begin
        cx_d = '0;
        cy_d = y_end ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx_o   = cx_q;
  assign cy_o   = cy_q;
  assign last_o = x_end && y_end;

endmodule

// File: rtl/tile_blitter.sv
// Scans one tile, fetches background/sprite pixels and streams them to the VGA adapter.
module tile_blitter
  import tile_pkg::*;
#(
  parameter int unsigned         TILE_W      = DEF_TILE_W,
  parameter int unsigned         TILE_H      = DEF_TILE_H,
  parameter int unsigned         SCREEN_W    = DEF_SCREEN_W,
  parameter int unsigned         SCREEN_H    = DEF_SCREEN_H,
  parameter int unsigned         GRID_W      = 4,
  parameter int unsigned         COLOR_W     = 9,
  parameter int unsigned         RD_LAT      = 1,
  parameter int unsigned         NUM_SPR     = 4,
  parameter logic [COLOR_W-1:0]  TRANSPARENT = {COLOR_W{1'b1}},
  parameter int unsigned         SEL_W       = clog2_min1(NUM_SPR),
  parameter int unsigned         BG_AW       = clog2_min1(SCREEN_W * SCREEN_H),
  parameter int unsigned         SPR_AW      = clog2_min1(NUM_SPR * TILE_W * TILE_H)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               mode,
  input  logic [GRID_W-1:0]  grid_x,
  input  logic [GRID_W-1:0]  grid_y,
  input  logic [SEL_W-1:0]   spr_sel,
  output logic [BG_AW-1:0]   bg_addr,
  input  logic [COLOR_W-1:0] bg_q,
  output logic [SPR_AW-1:0]  spr_addr,
  input  logic [COLOR_W-1:0] spr_q,
  output logic [7:0]         x,
  output logic [6:0]         y,
  output logic [COLOR_W-1:0] colour,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CX_W    = clog2_min1(TILE_W);
  localparam int unsigned CY_W    = clog2_min1(TILE_H);
  localparam int unsigned DRAIN_W = clog2_min1(RD_LAT + 1);
  localparam int unsigned LAST    = RD_LAT - 1;

  tile_state_e state_q, state_d;

  logic               mode_q;
  logic [GRID_W-1:0]  gx_q, gy_q;
  logic [SEL_W-1:0]   sel_q;
  logic [DRAIN_W-1:0] drain_q;
  logic               done_q;
  logic               accept, scan_en, drain_last, last_px;
  logic [CX_W-1:0]    cx;
  logic [CY_W-1:0]    cy;
  logic [31:0]        px_full, py_full, spr_full;
  logic               inb;

  // Coordinate pipeline; stage LAST lines up with the RAM data.
  logic               vld_p  [RD_LAT];
  logic               mode_p [RD_LAT];
  logic [7:0]         px_p   [RD_LAT];
  logic [6:0]         py_p   [RD_LAT];

  logic [7:0]         x_hold_q;
  logic [6:0]         y_hold_q;
  logic [COLOR_W-1:0] colour_hold_q, pix_colour;

  assign accept = (state_q == StIdle) && start;

  tile_scan_counter #(
    .TILE_W (TILE_W),
    .TILE_H (TILE_H)
  ) u_scan (
    .clk_i  (clk),
    .rst_ni (resetn),
    .clr_i  (accept),
    .en_i   (scan_en),
    .cx_o   (cx),
    .cy_o   (cy),
    .last_o (last_px)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start)      state_d = StScan;
      StScan:  if (last_px)    state_d = StDrain;
      StDrain: if (drain_last) state_d = StIdle;
      default:                 state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy       = (state_q != StIdle);
    scan_en    = (state_q == StScan);
    drain_last = (state_q == StDrain) && (drain_q == DRAIN_W'(LAST));
  end

  // Request latch, drain timer and done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_q  <= MODE_ERASE;
      gx_q    <= '0;
      gy_q    <= '0;
      sel_q   <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      if (accept) begin
        mode_q <= mode;
        gx_q   <= grid_x;
        gy_q   <= grid_y;
        sel_q  <= spr_sel;
      end
      drain_q <= (state_q == StDrain) ? drain_q + 1'b1 : '0;
      done_q  <= drain_last;
    end
  end

  assign done = done_q;

  // Address generation; products are formed at 32 bits before truncation.
  always_comb begin
    px_full  = 32'(gx_q) * TILE_W + 32'(cx);
    py_full  = 32'(gy_q) * TILE_H + 32'(cy);
    spr_full = 32'(sel_q) * TILE_W * TILE_H + 32'(cy) * TILE_W + 32'(cx);
    inb      = (px_full < SCREEN_W) && (py_full < SCREEN_H);
    bg_addr  = (scan_en && inb) ? BG_AW'(py_full * SCREEN_W + px_full) : '0;
    spr_addr = scan_en ? SPR_AW'(spr_full) : '0;
  end

  // Delay coordinates, mode and the plot qualifier to meet the RAM data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_p[i]  <= 1'b0;
        mode_p[i] <= MODE_ERASE;
        px_p[i]   <= '0;
        py_p[i]   <= '0;
      end
    end else begin
      vld_p[0]  <= scan_en && inb;
      mode_p[0] <= mode_q;
      px_p[0]   <= px_full[7:0];
      py_p[0]   <= py_full[6:0];
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i]  <= vld_p[i-1];
        mode_p[i] <= mode_p[i-1];
        px_p[i]   <= px_p[i-1];
        py_p[i]   <= py_p[i-1];
      end
    end
  end

  // Pixel output: live during a plot slot, otherwise the last plotted values.
  always_comb begin
    pix_colour = ((mode_p[LAST] == MODE_DRAW) && (spr_q != TRANSPARENT)) ? spr_q : bg_q;
    plot       = vld_p[LAST];
    x          = plot ? px_p[LAST] : x_hold_q;
    y          = plot ? py_p[LAST] : y_hold_q;
    colour     = plot ? pix_colour : colour_hold_q;
  end

  // Hold registers for the idle value of x/y/colour.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_hold_q      <= '0;
      y_hold_q      <= '0;
      colour_hold_q <= '0;
    end else if (plot) begin
      x_hold_q      <= px_p[LAST];
      y_hold_q      <= py_p[LAST];
      colour_hold_q <= pix_colour;
    end
  end

endmodule
